// File: rtl/filtro_nivel_temperatura.sv
// Debounce filter for the 2-bit temperature level, with asymmetric rise/fall hysteresis and a latched alarm.
// Optional macro FILTRO_NIVEL_ATALHO_EN: a sample of level 11 commits at once.
module filtro_nivel_temperatura #(
    parameter int unsigned N_SUBIDA  = 3,
    parameter int unsigned N_DESCIDA = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       amostra_pronta,
    input  logic [1:0] nivel_in,
    input  logic       reconhece,
    output logic [1:0] nivel_estavel,
    output logic       mudou,
    output logic       subindo,
    output logic       alarme
);

    localparam int unsigned CONT_W  = 4;
    localparam int unsigned NIVEL_W = 2;
    localparam logic [NIVEL_W-1:0] NIVEL_MAX = 2'b11;

    typedef enum logic [0:0] {
        ESTAVEL   = 1'b0,
        CANDIDATO = 1'b1
    } estado_t;

    estado_t             estado_q;
    logic [NIVEL_W-1:0]  nivel_q;
    logic [NIVEL_W-1:0]  candidato_q;
    logic [CONT_W-1:0]   cont_q;
    logic                mudou_q;
    logic                subindo_q;
    logic                alarme_q;

    logic                sobe_c;
    logic [CONT_W-1:0]   req_c;
    logic [CONT_W-1:0]   cont_prox_c;
    logic                difere_c;
    logic                atalho_c;
    logic                commit_c;

    // Threshold follows the direction of the incoming sample relative to the stable level.
    always_comb begin
        sobe_c      = (nivel_in > nivel_q);
        req_c       = sobe_c ? CONT_W'(N_SUBIDA) : CONT_W'(N_DESCIDA);
        difere_c    = (nivel_in != nivel_q);
        cont_prox_c = CONT_W'(1);
        if ((estado_q == CANDIDATO) && (nivel_in == candidato_q)) begin
            cont_prox_c = cont_q + CONT_W'(1);
        end
`ifdef FILTRO_NIVEL_ATALHO_EN
        atalho_c = (nivel_in == NIVEL_MAX);
`else
        atalho_c = 1'b0;
`endif
        commit_c = amostra_pronta && difere_c && ((cont_prox_c == req_c) || atalho_c);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= ESTAVEL;
            nivel_q     <= '0;
            candidato_q <= '0;
            cont_q      <= '0;
            mudou_q     <= 1'b0;
            subindo_q   <= 1'b0;
            alarme_q    <= 1'b0;
        end else begin
            mudou_q <= 1'b0;
            if (amostra_pronta) begin
                if (commit_c) begin
                    nivel_q   <= nivel_in;
                    subindo_q <= sobe_c;
                    mudou_q   <= 1'b1;
                    cont_q    <= '0;
                    estado_q  <= ESTAVEL;
                end else if (!difere_c) begin
                    cont_q   <= '0;
                    estado_q <= ESTAVEL;
                end else begin
                    candidato_q <= nivel_in;
                    cont_q      <= cont_prox_c;
                    estado_q    <= CANDIDATO;
                end
            end
            // Set on reaching the top level beats a simultaneous acknowledge.
            if (commit_c && (nivel_in == NIVEL_MAX)) begin
                alarme_q <= 1'b1;
            end else if (reconhece && (nivel_q != NIVEL_MAX)) begin
                alarme_q <= 1'b0;
            end
        end
    end

    assign nivel_estavel = nivel_q;
    assign mudou         = mudou_q;
    assign subindo       = subindo_q;
    assign alarme        = alarme_q;

endmodule

// File: tb/tb_filtro_nivel_temperatura.sv
// Directed bench for filtro_nivel_temperatura with default parameters.
module tb_filtro_nivel_temperatura;

    logic       clock;
    logic       reset;
    logic       amostra_pronta;
    logic [1:0] nivel_in;
    logic       reconhece;
    logic [1:0] nivel_estavel;
    logic       mudou;
    logic       subindo;
    logic       alarme;

    int n_cmp;
    int n_err;

    filtro_nivel_temperatura #(.N_SUBIDA(3), .N_DESCIDA(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .amostra_pronta (amostra_pronta),
        .nivel_in       (nivel_in),
        .reconhece      (reconhece),
        .nivel_estavel  (nivel_estavel),
        .mudou          (mudou),
        .subindo        (subindo),
        .alarme         (alarme)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change 1 time unit after a rising edge; outputs are read at the same offset.
    task automatic strobe(input logic [1:0] v);
        amostra_pronta = 1'b1;
        nivel_in       = v;
        @(posedge clock);
        #1;
        amostra_pronta = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        n_cmp++; if (nivel_estavel !== 2'b00) begin $display("FAIL reset_nivel got=%b exp=00", nivel_estavel); n_err++; end
        n_cmp++; if ({mudou, subindo, alarme} !== 3'b000) begin $display("FAIL reset_flags got=%b exp=000", {mudou, subindo, alarme}); n_err++; end
    endtask

    task automatic test_subida();
        strobe(2'b01);
        strobe(2'b01);
        n_cmp++; if (nivel_estavel !== 2'b00) begin $display("FAIL subida_early got=%b exp=00", nivel_estavel); n_err++; end
        strobe(2'b01);
        n_cmp++; if (nivel_estavel !== 2'b01) begin $display("FAIL subida_nivel got=%b exp=01", nivel_estavel); n_err++; end
        n_cmp++; if ({mudou, subindo, alarme} !== 3'b110) begin $display("FAIL subida_flags got=%b exp=110", {mudou, subindo, alarme}); n_err++; end
        idle(1);
        n_cmp++; if (mudou !== 1'b0) begin $display("FAIL subida_pulse got=%b exp=0", mudou); n_err++; end
    endtask

    task automatic test_descida_abort();
        for (int i = 0; i < 5; i++) strobe(2'b00);
        strobe(2'b01);
        n_cmp++; if ({nivel_estavel, mudou} !== 3'b010) begin $display("FAIL abort_hold got=%b exp=010", {nivel_estavel, mudou}); n_err++; end
        for (int i = 0; i < 5; i++) strobe(2'b00);
        n_cmp++; if (nivel_estavel !== 2'b01) begin $display("FAIL descida_early got=%b exp=01", nivel_estavel); n_err++; end
        strobe(2'b00);
        n_cmp++; if ({nivel_estavel, mudou, subindo} !== 4'b0010) begin $display("FAIL descida_commit got=%b exp=0010", {nivel_estavel, mudou, subindo}); n_err++; end
    endtask

    task automatic test_restart();
        int bad;
        bad = 0;
        strobe(2'b10); if (nivel_estavel !== 2'b00) bad++;
        strobe(2'b10); if (nivel_estavel !== 2'b00) bad++;
        strobe(2'b01); if (nivel_estavel !== 2'b00) bad++;
        strobe(2'b01); if (nivel_estavel !== 2'b00) bad++;
        n_cmp++; if (bad !== 0) begin $display("FAIL restart_hold bad_samples=%0d exp=0", bad); n_err++; end
        strobe(2'b01);
        n_cmp++; if ({nivel_estavel, mudou, subindo} !== 4'b0111) begin $display("FAIL restart_commit got=%b exp=0111", {nivel_estavel, mudou, subindo}); n_err++; end
        for (int i = 0; i < 6; i++) strobe(2'b00);
        n_cmp++; if (nivel_estavel !== 2'b00) begin $display("FAIL restart_return got=%b exp=00", nivel_estavel); n_err++; end
    endtask

    task automatic test_gaps();
        strobe(2'b01);
        idle(3);
        strobe(2'b01);
        idle(2);
        n_cmp++; if (nivel_estavel !== 2'b00) begin $display("FAIL gaps_early got=%b exp=00", nivel_estavel); n_err++; end
        strobe(2'b01);
        n_cmp++; if ({nivel_estavel, mudou} !== 3'b011) begin $display("FAIL gaps_commit got=%b exp=011", {nivel_estavel, mudou}); n_err++; end
        for (int i = 0; i < 6; i++) strobe(2'b00);
        n_cmp++; if (nivel_estavel !== 2'b00) begin $display("FAIL gaps_return got=%b exp=00", nivel_estavel); n_err++; end
    endtask

    task automatic test_alarme();
        for (int i = 0; i < 3; i++) strobe(2'b11);
        n_cmp++; if ({nivel_estavel, alarme, subindo} !== 4'b1111) begin $display("FAIL alarme_set got=%b exp=1111", {nivel_estavel, alarme, subindo}); n_err++; end
        reconhece = 1'b1;
        idle(2);
        reconhece = 1'b0;
        n_cmp++; if (alarme !== 1'b1) begin $display("FAIL alarme_ack_at_top got=%b exp=1", alarme); n_err++; end
        for (int i = 0; i < 6; i++) strobe(2'b10);
        n_cmp++; if ({nivel_estavel, alarme, subindo} !== 4'b1010) begin $display("FAIL alarme_descida got=%b exp=1010", {nivel_estavel, alarme, subindo}); n_err++; end
        reconhece = 1'b1;
        idle(1);
        reconhece = 1'b0;
        n_cmp++; if (alarme !== 1'b0) begin $display("FAIL alarme_clear got=%b exp=0", alarme); n_err++; end
        reconhece = 1'b1;
        for (int i = 0; i < 3; i++) strobe(2'b11);
        reconhece = 1'b0;
        n_cmp++; if ({nivel_estavel, alarme} !== 3'b111) begin $display("FAIL alarme_set_wins got=%b exp=111", {nivel_estavel, alarme}); n_err++; end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        strobe(2'b10);
        strobe(2'b10);
        pulse_reset();
        n_cmp++; if ({nivel_estavel, mudou, subindo, alarme} !== 5'b00000) begin $display("FAIL midreset_outs got=%b exp=00000", {nivel_estavel, mudou, subindo, alarme}); n_err++; end
        strobe(2'b10);
        n_cmp++; if ({nivel_estavel, mudou} !== 3'b000) begin $display("FAIL midreset_no_commit got=%b exp=000", {nivel_estavel, mudou}); n_err++; end
        strobe(2'b10);
        strobe(2'b10);
        n_cmp++; if ({nivel_estavel, mudou} !== 3'b101) begin $display("FAIL midreset_recount got=%b exp=101", {nivel_estavel, mudou}); n_err++; end
    endtask

    task automatic test_atalho();
        pulse_reset();
        strobe(2'b11);
`ifdef FILTRO_NIVEL_ATALHO_EN
        n_cmp++; if ({nivel_estavel, mudou, alarme, subindo} !== 5'b11111) begin $display("FAIL atalho_commit got=%b exp=11111", {nivel_estavel, mudou, alarme, subindo}); n_err++; end
`else
        n_cmp++; if ({nivel_estavel, mudou, alarme} !== 4'b0000) begin $display("FAIL atalho_off got=%b exp=0000", {nivel_estavel, mudou, alarme}); n_err++; end
`endif
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        reset          = 1'b1;
        amostra_pronta = 1'b0;
        nivel_in       = 2'b00;
        reconhece      = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_subida();
        test_descida_abort();
        test_restart();
        test_gaps();
        test_alarme();
        test_reset_mid();
        test_atalho();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/filtro_nivel_temperatura.md
Name: filtro_nivel_temperatura

Overview:
Downstream consumer of the 2-bit temperature level produced by the four-threshold temperature comparator.
- Debounces that level with asymmetric hysteresis: a new level is accepted only after N consecutive agreeing samples, with separate counts for rising and falling.
- Publishes a stable level, a one-cycle change pulse and a latched over-temperature alarm to the control FSM.

Parameters:
N_SUBIDA, 3, consecutive agreeing samples needed to accept a higher level (legal 1..15).
N_DESCIDA, 6, consecutive agreeing samples needed to accept a lower level (legal 1..15).

Ports:
clock  input  1  system clock; all state on rising edge.
reset  input  1  synchronous, active-high reset.
amostra_pronta  input  1  one-cycle strobe; nivel_in is valid this cycle.
nivel_in  input  2  raw level from comparator (00 coldest .. 11 hottest).
reconhece  input  1  operator acknowledge for the alarm; level-sensitive.
nivel_estavel  output  2  debounced level.
mudou  output  1  one-cycle pulse when nivel_estavel changes.
subindo  output  1  direction of last accepted change (1 = rose); held.
alarme  output  1  latched over-temperature alarm.

Behaviour:
- Reset, synchronous, priority over everything: nivel_estavel=00, mudou=0, subindo=0, alarme=0, internal candidato=00, cont=0, state=ESTAVEL. Reset asserted mid-count discards the candidate.
- Samples are ignored unless amostra_pronta=1. Between strobes, all state holds and mudou=0.
- Required count req = N_SUBIDA if candidate > nivel_estavel, else N_DESCIDA. The comparison is unsigned on 2 bits.
- State ESTAVEL, on strobe:
  - nivel_in == nivel_estavel: stay; cont=0.
  - Otherwise: candidato=nivel_in, cont=1, go to CANDIDATO.
  - If req==1, commit immediately instead (see commit).
- State CANDIDATO, on strobe:
  - nivel_in == nivel_estavel: abort; cont=0, back to ESTAVEL.
  - nivel_in != candidato and != nivel_estavel: restart with candidato=nivel_in, cont=1. The threshold is recomputed for the new direction.
  - nivel_in == candidato: cont=cont+1. If the new count == req, commit.
- Commit, registered on the strobe edge:
  - nivel_estavel=candidato; subindo=(candidato>old nivel_estavel); mudou=1 for exactly that one cycle.
  - cont=0; state=ESTAVEL.
- Latency: nivel_estavel and mudou update on the clock edge that samples the qualifying strobe. They are visible the cycle after the strobe.
- A multi-step jump (e.g. 00 to 11) commits directly; there are no intermediate levels.
- cont is 4 bits wide and never exceeds req, so it cannot wrap.
- Alarm:
  - alarme is set on any commit to 11.
  - alarme is cleared on a clock edge where reconhece=1 and nivel_estavel (current registered value) != 11.
  - reconhece while nivel_estavel==11 has no effect.
  - If a commit to 11 and reconhece occur in the same cycle, set wins.
  - Descending from 11 does not clear alarme without reconhece.

Optional Feature:
Macro FILTRO_NIVEL_ATALHO_EN.
- Defined: a strobe with nivel_in==11 while nivel_estavel!=11 commits to 11 on that same strobe, regardless of N_SUBIDA or current candidate. Normal commit rules apply (mudou, subindo=1, alarme set). Falling transitions are unchanged.
- Undefined: level 11 obeys the normal N_SUBIDA rule.

Test Plan:
1. Reset, then 3 strobes of nivel_in=01 (defaults) -> after third strobe nivel_estavel=01, mudou=1 one cycle, subindo=1, alarme=0.
2. From 01: strobes 00,00,00,00,00,01 -> no change, candidate aborted. Then 6 strobes of 00 -> nivel_estavel=00 after sixth, subindo=0, mudou pulse.
3. From 00: strobes 10,10,01,01,01 -> candidate restarts at 01; nivel_estavel=01 after fifth strobe, never 10.
4. From 00: 3 strobes of 11 -> nivel_estavel=11, alarme=1. Hold reconhece=1 -> alarme stays 1. Then 6 strobes of 10 -> nivel_estavel=10; next edge with reconhece=1 -> alarme=0.
5. Mid-candidate (2 of 3 strobes of 10 from 00), assert reset one cycle -> all outputs 00/0. The next single strobe of 10 does not commit.
6. With FILTRO_NIVEL_ATALHO_EN, from 00: one strobe of 11 -> nivel_estavel=11, alarme=1, mudou=1 next cycle. Without the macro, the same stimulus leaves nivel_estavel=00.
